// File: rtl/edlo_pkg.sv
// Shared definitions for the serial transmitter of the adder result byte.
//   tx_state_e           : transmitter FSM states
//   DEFAULT_CLKS_PER_BIT : 50 MHz clock / 115200 baud
//   DEFAULT_FIFO_DEPTH   : byte entries in the input buffer
//   BYTE_W               : width of one buffered byte
//   even_parity()        : parity bit that makes the total count of ones even
package edlo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int BYTE_W               = 8;

    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/edlo_sync_fifo.sv
// Single-clock byte FIFO feeding the serial transmitter.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (pointers and count only)
//   push      : write push_data this edge (ignored when full)
//   push_data : byte to store
//   pop       : drop the head entry this edge (ignored when empty)
//   pop_data  : head entry, valid while not empty
//   count     : number of stored entries, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module edlo_sync_fifo
    import edlo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // A full FIFO refuses a push even when a pop frees a slot at the same edge.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/edlo_sum_uart_tx.sv
// Buffered UART transmitter for the adder result byte.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset; aborts any frame
//   ena        : design enable; 0 freezes FSM, timer, shift register, FIFO
//   data_in    : byte to send
//   data_valid : data_in holds a byte to send
//   data_ready : byte can be accepted this cycle (FIFO not full and ena)
//   tx         : serial line, start bit, 8 data bits LSB first,
//                optional even parity, stop bit; idle high
//   busy       : FIFO non-empty or frame in progress
//   fifo_count : number of buffered bytes
module edlo_sum_uart_tx
    import edlo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count
);

    localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [15:0]       timer;
    logic [15:0]       timer_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic [BYTE_W-1:0] shift_reg;
    logic [BYTE_W-1:0] shift_nxt;
    logic              par_bit;
    logic              par_nxt;
    logic              load_frame;
    logic              pop_req;

    logic              push;
    logic [BYTE_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;

    assign data_ready = ~fifo_full & ena;
    assign push       = data_valid & data_ready;
    assign fifo_count = 3'(fifo_cnt);
    assign busy       = (state != ST_IDLE) | ~fifo_empty;

    edlo_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_in),
        .pop       (pop_req),
        .pop_data  (fifo_head),
        .count     (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Payload registers need no reset: they are only read after a load.
    always_ff @(posedge clk) begin
        shift_reg <= shift_nxt;
        par_bit   <= par_nxt;
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        par_nxt     = par_bit;
        load_frame  = 1'b0;
        pop_req     = 1'b0;

        // With ena low every *_nxt keeps its default, freezing the FSM.
        if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) load_frame = 1'b1;
                end
                ST_START: begin
                    if (timer == '0) begin
                        state_nxt = ST_DATA;
                        timer_nxt = BIT_LOAD;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (timer == '0) begin
                        timer_nxt   = BIT_LOAD;
                        shift_nxt   = {1'b0, shift_reg[BYTE_W-1:1]};
                        // 3-bit index wraps 7 -> 0 as the last data bit ends.
                        bit_idx_nxt = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (timer == '0) begin
                        state_nxt = ST_STOP;
                        timer_nxt = BIT_LOAD;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (timer == '0) begin
                        // Chain straight into the next frame when bytes wait.
                        if (!fifo_empty) load_frame = 1'b1;
                        else             state_nxt  = ST_IDLE;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end

        if (load_frame) begin
            pop_req   = 1'b1;
            shift_nxt = fifo_head;
            par_nxt   = even_parity(fifo_head);
            timer_nxt = BIT_LOAD;
            state_nxt = ST_START;
        end
    end

    // tx decodes registered state, so it holds while frozen and goes high
    // the moment reset forces IDLE.
    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_reg[0];
            ST_PARITY: tx = par_bit;
            default:   tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_edlo_sum_uart_tx.sv
module tb_edlo_sum_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       ena0, dv0, rdy0, tx0, busy0;
    logic [7:0] din0;
    logic [2:0] cnt0;
    logic       ena1, dv1, rdy1, tx1, busy1;
    logic [7:0] din1;
    logic [2:0] cnt1;

    int   n_cmp;
    int   n_err;
    logic txbuf [0:199];
    int   k;

    edlo_sum_uart_tx #(
        .CLKS_PER_BIT (4),
        .PARITY_EN    (0),
        .FIFO_DEPTH   (4)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena0),
        .data_in    (din0),
        .data_valid (dv0),
        .data_ready (rdy0),
        .tx         (tx0),
        .busy       (busy0),
        .fifo_count (cnt0)
    );

    edlo_sum_uart_tx #(
        .CLKS_PER_BIT (4),
        .PARITY_EN    (1),
        .FIFO_DEPTH   (4)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena1),
        .data_in    (din1),
        .data_valid (dv1),
        .data_ready (rdy1),
        .tx         (tx1),
        .busy       (busy1),
        .fifo_count (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at the sample point of bit-cycle 'first'; checks tx each cycle
    // to the end of the frame, then that the line is idle.
    task automatic frame(input bit sel, input logic [10:0] bits, input int nbits,
                         input int first, input string tag);
        for (int i = first; i < nbits * 4; i++) begin
            check(tag, sel ? tx1 : tx0, 32'(bits[i / 4]));
            if (i == nbits * 4 - 1) check({tag, "_busy_last"}, sel ? busy1 : busy0, 1);
            step();
        end
        check({tag, "_busy_end"}, sel ? busy1 : busy0, 0);
        check({tag, "_tx_end"}, sel ? tx1 : tx0, 1);
    endtask

    // Push five consecutive bytes on dut0, one per edge, recording tx from
    // the edge where the first frame starts.
    task automatic push_burst(input logic [7:0] first_byte, input string tag);
        k = 0;
        for (int j = 0; j < 5; j++) begin
            din0 = first_byte + 8'(j);
            dv0  = 1'b1;
            step();
            check({tag, "_cnt"}, cnt0, (j == 0) ? 1 : j);
            check({tag, "_rdy"}, rdy0, (j < 4) ? 1 : 0);
            if (j >= 1) begin
                txbuf[k] = tx0;
                k++;
            end
        end
        dv0 = 1'b0;
    endtask

    initial begin
        logic [7:0] rx_byte;
        logic [7:0] rst_bytes [3];
        int         lows;
        int         busy_seen;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ena0 = 1'b1; dv0 = 1'b0; din0 = 8'h00;
        ena1 = 1'b1; dv1 = 1'b0; din1 = 8'h00;
        rst_bytes[0] = 8'h55; rst_bytes[1] = 8'h66; rst_bytes[2] = 8'h77;

        // Reset state
        #3;
        check("rst_tx", tx0, 1);
        check("rst_busy", busy0, 0);
        check("rst_cnt", cnt0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        check("rel_rdy", rdy0, 1);
        step();

        // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 each 4 cycles
        din0 = 8'hA5; dv0 = 1'b1;
        step();
        dv0 = 1'b0;
        check("a5_cnt", cnt0, 1);
        check("a5_tx_pre", tx0, 1);
        step();
        frame(1'b0, 11'b0_1101001010, 10, 0, "a5");

        // 0x07 with even parity: parity bit 1, 44-cycle frame
        din1 = 8'h07; dv1 = 1'b1;
        step();
        dv1 = 1'b0;
        step();
        frame(1'b1, 11'b11000001110, 11, 0, "par07");

        // Five bytes back to back, contiguous in-order frames
        push_burst(8'h01, "burst");
        while (k < 200) begin
            step();
            txbuf[k] = tx0;
            k++;
        end
        for (int f = 0; f < 5; f++) begin
            check("burst_start", 32'(txbuf[f * 40 + 2]), 0);
            for (int b = 0; b < 8; b++) rx_byte[b] = txbuf[f * 40 + (b + 1) * 4 + 2];
            check("burst_byte", rx_byte, f + 1);
            check("burst_stop", 32'(txbuf[f * 40 + 38]), 1);
        end
        step();
        check("burst_idle", busy0, 0);

        // Full FIFO: push at the STOP-ending edge refused, accepted next edge
        push_burst(8'h11, "full");
        repeat (36) step();
        check("full_cnt4", cnt0, 4);
        check("full_rdy0", rdy0, 0);
        din0 = 8'hFF; dv0 = 1'b1;
        step();
        check("full_cnt3", cnt0, 3);
        step();
        check("full_cnt4b", cnt0, 4);
        dv0 = 1'b0;
        for (int c = 0; c < 400 && busy0; c++) step();
        check("full_drain", busy0, 0);

        // Reset during DATA bit 3 with two bytes buffered
        for (int j = 0; j < 3; j++) begin
            din0 = rst_bytes[j]; dv0 = 1'b1;
            step();
        end
        dv0 = 1'b0;
        check("mid_cnt", cnt0, 2);
        repeat (16) step();
        check("mid_tx_bit3", tx0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx0, 1);
        check("mid_rst_cnt", cnt0, 0);
        check("mid_rst_busy", busy0, 0);
        #1 rst_n = 1'b1;
        lows = 0;
        busy_seen = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (tx0 !== 1'b1) lows++;
            if (busy0 !== 1'b0) busy_seen++;
        end
        check("post_rst_tx_low", lows, 0);
        check("post_rst_busy", busy_seen, 0);
        check("post_rst_rdy", rdy0, 1);

        // Enable dropped for 10 cycles in the middle of START
        din0 = 8'hC3; dv0 = 1'b1;
        step();
        dv0 = 1'b0;
        step();
        check("en_start0", tx0, 0);
        step();
        check("en_start1", tx0, 0);
        ena0 = 1'b0;
        #1;
        check("en_rdy_off", rdy0, 0);
        for (int c = 0; c < 10; c++) begin
            step();
            check("en_hold_tx", tx0, 0);
        end
        check("en_hold_busy", busy0, 1);
        ena0 = 1'b1;
        step();
        frame(1'b0, 11'b0_1110000110, 10, 2, "en_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
